// File: rtl/byte_packer_fsm.sv
// Packs PACK consecutive bytes from an input RAM into one output-RAM word, num_words times.
// Optional PACKER_CSUM_EN adds a csum output that is the XOR of every word written in a run.
module byte_packer_fsm #(
   parameter int BYTE_W = 8,
   parameter int PACK   = 2,
   parameter int IN_AW  = 2,
   parameter int OUT_AW = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [OUT_AW:0]          num_words,
   input  logic                     big_endian,
   output logic [IN_AW-1:0]         in_rd_addr,
   input  logic [BYTE_W-1:0]        in_rd_data,
   output logic                     out_we,
   output logic [OUT_AW-1:0]        out_addr,
   output logic [PACK*BYTE_W-1:0]   out_data,
   output logic                     busy,
   output logic                     done
`ifdef PACKER_CSUM_EN
   ,
   output logic [PACK*BYTE_W-1:0]   csum
`endif
);

   localparam int OUT_W = PACK * BYTE_W;
   localparam int CW    = $clog2(PACK);

   typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [OUT_AW:0]    num_q, num_d;
   logic               be_q, be_d;
   logic [IN_AW-1:0]   rd_addr_q, rd_addr_d;
   logic [OUT_W-1:0]   sh_q, sh_d;
   logic [OUT_AW:0]    wcnt_q, wcnt_d;
   logic [OUT_AW-1:0]  oaddr_q, oaddr_d;
   logic [OUT_W-1:0]   odata_q, odata_d;
   logic [OUT_W-1:0]   word_le, word_be, word_pk;
`ifdef PACKER_CSUM_EN
   logic [OUT_W-1:0]   csum_q, csum_d;
`endif

   // The shift register sees one stale byte per word (RD cycle 0); it falls off the bottom
   // before LAST, so the little-endian word is simply the newest PACK bytes.
   assign word_le = {in_rd_data, sh_q[OUT_W-1:BYTE_W]};

   always_comb begin
      word_be = '0;
      for (int i = 0; i < PACK; i++) begin
         word_be[(PACK-1-i)*BYTE_W +: BYTE_W] = word_le[i*BYTE_W +: BYTE_W];
      end
      word_pk = be_q ? word_be : word_le;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      num_d     = num_q;
      be_d      = be_q;
      rd_addr_d = rd_addr_q;
      sh_d      = sh_q;
      wcnt_d    = wcnt_q;
      oaddr_d   = oaddr_q;
      odata_d   = odata_q;
`ifdef PACKER_CSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               num_d     = num_words;
               be_d      = big_endian;
               rd_addr_d = '0;
               cnt_d     = '0;
               wcnt_d    = '0;
               oaddr_d   = '0;
`ifdef PACKER_CSUM_EN
               csum_d    = '0;
`endif
               state_d   = (num_words == '0) ? DONE : RD;
            end
         end
         RD: begin
            sh_d      = word_le;
            rd_addr_d = rd_addr_q + IN_AW'(1);
            if (cnt_q == CW'(PACK-1)) begin
               cnt_d   = '0;
               state_d = LAST;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         LAST: begin
            odata_d = word_pk;
            state_d = WR;
         end
         WR: begin
`ifdef PACKER_CSUM_EN
            csum_d  = csum_q ^ odata_q;
`endif
            oaddr_d = oaddr_q + OUT_AW'(1);
            wcnt_d  = wcnt_q + (OUT_AW+1)'(1);
            state_d = (wcnt_d == num_q) ? DONE : RD;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         num_q     <= '0;
         be_q      <= 1'b0;
         rd_addr_q <= '0;
         sh_q      <= '0;
         wcnt_q    <= '0;
         oaddr_q   <= '0;
         odata_q   <= '0;
`ifdef PACKER_CSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         num_q     <= num_d;
         be_q      <= be_d;
         rd_addr_q <= rd_addr_d;
         sh_q      <= sh_d;
         wcnt_q    <= wcnt_d;
         oaddr_q   <= oaddr_d;
         odata_q   <= odata_d;
`ifdef PACKER_CSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign in_rd_addr = rd_addr_q;
   assign out_we     = (state_q == WR);
   assign out_addr   = oaddr_q;
   assign out_data   = odata_q;
   assign busy       = (state_q == RD) || (state_q == LAST) || (state_q == WR);
   assign done       = (state_q == DONE);
`ifdef PACKER_CSUM_EN
   assign csum       = csum_q;
`endif

endmodule

// File: tb/tb_byte_packer_fsm.sv
// Bench for byte_packer_fsm: per-cycle comparison against a word-level model, plus literal checks.
module tb_byte_packer_fsm;

   localparam int BYTE_W = 8;
   localparam int PACK   = 2;
   localparam int IN_AW  = 2;
   localparam int OUT_AW = 1;
   localparam int OUT_W  = PACK * BYTE_W;
   localparam int RAMSZ  = 1 << IN_AW;
   localparam int OSZ    = 1 << OUT_AW;
   localparam int T      = PACK + 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [OUT_AW:0]    num_words = '0;
   logic               big_endian = 1'b0;
   logic [IN_AW-1:0]   in_rd_addr;
   logic [BYTE_W-1:0]  in_rd_data;
   logic               out_we;
   logic [OUT_AW-1:0]  out_addr;
   logic [OUT_W-1:0]   out_data;
   logic               busy;
   logic               done;
`ifdef PACKER_CSUM_EN
   logic [OUT_W-1:0]   csum;
`endif

   byte_packer_fsm #(.BYTE_W(BYTE_W), .PACK(PACK), .IN_AW(IN_AW), .OUT_AW(OUT_AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
      .big_endian(big_endian), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
      .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
      .busy(busy), .done(done)
`ifdef PACKER_CSUM_EN
      , .csum(csum)
`endif
   );

   always #5 clk = ~clk;

   logic [BYTE_W-1:0] ram [RAMSZ];
   always @(posedge clk) in_rd_data <= ram[in_rd_addr];

   int n_vec = 0;
   int n_err = 0;

   logic [OUT_W-1:0] wr_dat[$];
   int               wr_adr[$];
   int               done_cyc;
   int               done_n;
   int               busy_n;
   logic [OUT_W-1:0] exp_csum;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Word w of a run takes bytes w*PACK .. w*PACK+PACK-1 (mod RAM size), first byte in the low
   // lane unless big-endian.
   function automatic logic [OUT_W-1:0] model_word(input int w, input bit be);
      logic [OUT_W-1:0] r;
      int lane;
      r = '0;
      for (int i = 0; i < PACK; i++) begin
         lane = be ? (PACK - 1 - i) : i;
         r[lane*BYTE_W +: BYTE_W] = ram[(w*PACK + i) % RAMSZ];
      end
      return r;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_addr"}, in_rd_addr, 0);
      chk({tag, "_we"}, out_we, 0);
      chk({tag, "_addr"}, out_addr, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
`ifdef PACKER_CSUM_EN
      chk({tag, "_csum"}, csum, 0);
`endif
   endtask

   task automatic run(input int n, input bit be, input bit extra, input int abort_at);
      int tot, w, p;
      logic e_we, e_busy, e_done;
      logic [OUT_W-1:0] e_word;
      tot = n * T;
      wr_dat.delete();
      wr_adr.delete();
      done_cyc = -1;
      done_n   = 0;
      busy_n   = 0;
      exp_csum = '0;
      @(negedge clk);
      start      = 1'b1;
      num_words  = n[OUT_AW:0];
      big_endian = be;
      @(posedge clk);
      #1;
      start      = 1'b0;
      num_words  = OUT_AW'($urandom);
      big_endian = ~be;
      for (int c = 1; c <= tot + 2; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         w = 0;
         p = 0;
         if (c <= tot) begin
            w      = (c - 1) / T;
            p      = (c - 1) % T;
            e_busy = 1'b1;
            e_done = 1'b0;
            e_we   = (p == T - 1);
            if (p < PACK) chk("rd_addr", in_rd_addr, (w*PACK + p) % RAMSZ);
         end else begin
            e_busy = 1'b0;
            e_we   = 1'b0;
            e_done = (c == tot + 1);
         end
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("out_we", out_we, e_we);
         if (e_we) begin
            e_word = model_word(w, be);
            chk("out_addr", out_addr, w % OSZ);
            chk("out_data", out_data, e_word);
            exp_csum ^= e_word;
         end
         if (n == 0 && c == 1) chk("rd_addr_n0", in_rd_addr, 0);
`ifdef PACKER_CSUM_EN
         if (c > tot) chk("csum", csum, exp_csum);
`endif
         if (out_we) begin
            wr_dat.push_back(out_data);
            wr_adr.push_back(int'(out_addr));
         end
         if (done) begin
            done_cyc = c;
            done_n++;
         end
         if (busy) busy_n++;
         if (c == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_all_zero("rst_mid");
            repeat (2) begin
               @(posedge clk);
               #1;
               chk("we_in_rst", out_we, 0);
            end
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (extra && (c == tot + 1 || (c == 2 && c <= tot))) begin
            start      = 1'b1;
            num_words  = OUT_AW'($urandom);
            big_endian = 1'($urandom);
         end
      end
   endtask

   task automatic chk_two_words(input logic [OUT_W-1:0] d0, input logic [OUT_W-1:0] d1);
      chk("n_writes", wr_dat.size(), 2);
      if (wr_dat.size() == 2) begin
         chk("w0_data", wr_dat[0], d0);
         chk("w0_addr", wr_adr[0], 0);
         chk("w1_data", wr_dat[1], d1);
         chk("w1_addr", wr_adr[1], 1);
      end
      chk("done_cyc", done_cyc, 9);
      chk("busy_cycles", busy_n, 8);
   endtask

   initial begin
      ram[0] = 8'h11;
      ram[1] = 8'h22;
      ram[2] = 8'h33;
      ram[3] = 8'h44;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run(2, 1'b0, 1'b0, 0);
      chk_two_words(16'h2211, 16'h4433);

      run(2, 1'b1, 1'b0, 0);
      chk_two_words(16'h1122, 16'h3344);
`ifdef PACKER_CSUM_EN
      chk("csum_lit", csum, 16'h2266);
`endif

      run(0, 1'b0, 1'b0, 0);
      chk("n0_writes", wr_dat.size(), 0);
      chk("n0_done_cyc", done_cyc, 1);

      run(3, 1'b0, 1'b0, 0);
      chk("n3_writes", wr_dat.size(), 3);
      if (wr_dat.size() == 3) begin
         chk("n3_w2_data", wr_dat[2], 16'h2211);
         chk("n3_w2_addr", wr_adr[2], 0);
      end
      chk("n3_done_cyc", done_cyc, 13);

      run(2, 1'b0, 1'b0, T);
      run(2, 1'b0, 1'b0, 0);
      chk_two_words(16'h2211, 16'h4433);

      run(2, 1'b0, 1'b1, 0);
      chk("extra_writes", wr_dat.size(), 2);
      chk("extra_done_n", done_n, 1);

      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < RAMSZ; i++) ram[i] = BYTE_W'($urandom);
         run($urandom_range(0, 3), 1'($urandom), 1'($urandom), 0);
         chk("rnd_done_n", done_n, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
